// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage interlock controller: opcode and
// ALU_op encodings, controller state encoding, and instruction classifiers.
package decode_hazard_ctrl_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    function automatic logic is_lw(input logic [4:0] opcode);
        return opcode == OP_LW;
    endfunction

    function automatic logic is_md(input logic [4:0] opcode, input logic [4:0] alu_op);
        return (opcode == OP_RTYPE) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));
    endfunction

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Pipeline-side bundle for the decode hazard controller. The pipeline
// (master) supplies decode/execute fields and the multdiv ready pulse; the
// controller (slave) returns the latch and multdiv sequencing controls.
interface decode_hazard_ctrl_if;
    logic [4:0] dec_opcode;
    logic [4:0] dec_alu_op;
    logic [4:0] dec_readRegA;
    logic [4:0] dec_readRegB;
    logic       dec_valid;
    logic [4:0] ex_opcode;
    logic [4:0] ex_rd;
    logic       ex_valid;
    logic       ex_branch_taken;
    logic       md_ready;
    logic       stall_fd;
    logic       bubble_dx;
    logic       flush_fd;
    logic       md_start;
    logic       md_busy;
    logic       md_timeout;

    modport master (
        output dec_opcode, dec_alu_op, dec_readRegA, dec_readRegB, dec_valid,
        output ex_opcode, ex_rd, ex_valid, ex_branch_taken, md_ready,
        input  stall_fd, bubble_dx, flush_fd, md_start, md_busy, md_timeout
    );

    modport slave (
        input  dec_opcode, dec_alu_op, dec_readRegA, dec_readRegB, dec_valid,
        input  ex_opcode, ex_rd, ex_valid, ex_branch_taken, md_ready,
        output stall_fd, bubble_dx, flush_fd, md_start, md_busy, md_timeout
    );
endinterface

// File: rtl/decode_hazard_ctrl_hazard_detect.sv
// Load-use hazard detector: a lw in execute whose destination is read by the
// instruction in decode. Register 0 is hardwired and never creates a hazard.
module decode_hazard_ctrl_hazard_detect
    import decode_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_opcode,
    input  logic [4:0] ex_rd,
    input  logic       ex_valid,
    input  logic [4:0] dec_readRegA,
    input  logic [4:0] dec_readRegB,
    input  logic       dec_valid,
    output logic       load_use
);

    // Hazard when a real lw writes a nonzero register that decode reads.
    always_comb begin
        load_use = ex_valid && is_lw(ex_opcode) && (ex_rd != 5'd0) && dec_valid &&
                   ((ex_rd == dec_readRegA) || (ex_rd == dec_readRegB));
    end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage interlock controller. Produces stall/bubble/flush controls for
// the F/D and D/X latches and sequences the multi-cycle multdiv unit with a
// watchdog. Outputs are combinational from state and inputs so a stall can
// take effect in the same cycle the hazard is seen.
// Optional stall-cycle performance counter: define HAZARD_PERF_CNT_EN.
module decode_hazard_ctrl
    import decode_hazard_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
`ifdef HAZARD_PERF_CNT_EN
    input  logic        perf_clear,
    output logic [31:0] stall_cycles,
`endif
    decode_hazard_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             load_use;
    logic             busy_hold;
    logic             timeout_hit;
    logic             md_go;
    logic             stall_fd, bubble_dx, flush_fd, md_start, md_busy, md_timeout;

    decode_hazard_ctrl_hazard_detect u_hazard_detect (
        .ex_opcode    (bus.ex_opcode),
        .ex_rd        (bus.ex_rd),
        .ex_valid     (bus.ex_valid),
        .dec_readRegA (bus.dec_readRegA),
        .dec_readRegB (bus.dec_readRegB),
        .dec_valid    (bus.dec_valid),
        .load_use     (load_use)
    );

    // Classify the cycle. md_ready releases MD_BUSY in the same cycle, so that
    // cycle is handled with IDLE priorities (allows back-to-back multdiv).
    always_comb begin
        busy_hold   = (state_reg == MD_BUSY) && !bus.md_ready;
        timeout_hit = busy_hold && (cnt_reg == CNT_LAST);
        md_go       = !busy_hold && !bus.ex_branch_taken && !load_use &&
                      bus.dec_valid && is_md(bus.dec_opcode, bus.dec_alu_op);
    end

    // Mealy control outputs; branch squash outranks load-use outranks multdiv launch.
    always_comb begin
        stall_fd   = 1'b0;
        bubble_dx  = 1'b0;
        flush_fd   = 1'b0;
        md_start   = 1'b0;
        md_busy    = 1'b0;
        md_timeout = 1'b0;
        if (busy_hold) begin
            stall_fd   = 1'b1;
            bubble_dx  = 1'b1;
            md_busy    = 1'b1;
            // A reset arriving on the watchdog cycle abandons silently.
            md_timeout = timeout_hit && !reset;
        end else if (bus.ex_branch_taken) begin
            flush_fd  = 1'b1;
            bubble_dx = 1'b1;
        end else if (load_use) begin
            stall_fd  = 1'b1;
            bubble_dx = 1'b1;
        end else if (md_go) begin
            md_start = 1'b1;
        end
    end

    // Next state and multdiv cycle counter.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (md_go) begin
            state_next = MD_BUSY;
            cnt_next   = '0;
        end else if (busy_hold) begin
            if (timeout_hit) begin
                state_next = IDLE;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end else begin
            state_next = IDLE;
            cnt_next   = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.stall_fd   = stall_fd;
    assign bus.bubble_dx  = bubble_dx;
    assign bus.flush_fd   = flush_fd;
    assign bus.md_start   = md_start;
    assign bus.md_busy    = md_busy;
    assign bus.md_timeout = md_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_reg;

    // Saturating count of cycles the front end is held; clear wins over count.
    always_ff @(posedge clock) begin
        if (reset || perf_clear) begin
            stall_cycles_reg <= '0;
        end else if (stall_fd && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed testbench for decode_hazard_ctrl. Two instances share stimulus:
// dut uses the default watchdog (40), dut_to uses MD_TIMEOUT=8.
// Output vectors are packed {stall_fd, bubble_dx, flush_fd, md_start, md_busy, md_timeout}.
module tb_decode_hazard_ctrl;
    import decode_hazard_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    decode_hazard_ctrl_if if0 ();
    decode_hazard_ctrl_if if1 ();

    assign if1.dec_opcode      = if0.dec_opcode;
    assign if1.dec_alu_op      = if0.dec_alu_op;
    assign if1.dec_readRegA    = if0.dec_readRegA;
    assign if1.dec_readRegB    = if0.dec_readRegB;
    assign if1.dec_valid       = if0.dec_valid;
    assign if1.ex_opcode       = if0.ex_opcode;
    assign if1.ex_rd           = if0.ex_rd;
    assign if1.ex_valid        = if0.ex_valid;
    assign if1.ex_branch_taken = if0.ex_branch_taken;
    assign if1.md_ready        = if0.md_ready;

`ifdef HAZARD_PERF_CNT_EN
    logic        perf_clear;
    logic [31:0] stall_cycles;
    logic [31:0] stall_cycles_to;
`endif

    decode_hazard_ctrl dut (
        .clock        (clock),
        .reset        (reset),
`ifdef HAZARD_PERF_CNT_EN
        .perf_clear   (perf_clear),
        .stall_cycles (stall_cycles),
`endif
        .bus          (if0)
    );

    decode_hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(4)) dut_to (
        .clock        (clock),
        .reset        (reset),
`ifdef HAZARD_PERF_CNT_EN
        .perf_clear   (perf_clear),
        .stall_cycles (stall_cycles_to),
`endif
        .bus          (if1)
    );

    wire [5:0] o0 = {if0.stall_fd, if0.bubble_dx, if0.flush_fd, if0.md_start, if0.md_busy, if0.md_timeout};
    wire [5:0] o1 = {if1.stall_fd, if1.bubble_dx, if1.flush_fd, if1.md_start, if1.md_busy, if1.md_timeout};

    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_STALL = 6'b110000;
    localparam logic [5:0] O_FLUSH = 6'b011000;
    localparam logic [5:0] O_START = 6'b000100;
    localparam logic [5:0] O_BUSY  = 6'b110010;
    localparam logic [5:0] O_TOUT  = 6'b110011;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        if0.dec_opcode      = 5'b00010;
        if0.dec_alu_op      = 5'd0;
        if0.dec_readRegA    = 5'd0;
        if0.dec_readRegB    = 5'd0;
        if0.dec_valid       = 1'b0;
        if0.ex_opcode       = OP_RTYPE;
        if0.ex_rd           = 5'd0;
        if0.ex_valid        = 1'b0;
        if0.ex_branch_taken = 1'b0;
        if0.md_ready        = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb);
        if0.ex_valid     = 1'b1;
        if0.ex_opcode    = OP_LW;
        if0.ex_rd        = rd;
        if0.dec_valid    = 1'b1;
        if0.dec_opcode   = 5'b00010;
        if0.dec_readRegA = ra;
        if0.dec_readRegB = rb;
    endtask

    task automatic set_dec_md(input logic [4:0] alu);
        if0.dec_valid  = 1'b1;
        if0.dec_opcode = OP_RTYPE;
        if0.dec_alu_op = alu;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL reset_dut got %b want %b", o0, O_NONE); end
        checks++; if (o1 !== O_NONE) begin errors++; $display("FAIL reset_dut_to got %b want %b", o1, O_NONE); end
        step();
    endtask

    task automatic test_load_use();
        set_load_use(5'd5, 5'd5, 5'd9);
        #4;
        checks++; if (o0 !== O_STALL) begin errors++; $display("FAIL lu_regA got %b want %b", o0, O_STALL); end
        step();
        if0.ex_valid = 1'b0;  // bubble now sits in execute, decode unchanged
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL lu_one_cycle got %b want %b", o0, O_NONE); end
        step();
        set_load_use(5'd7, 5'd3, 5'd7);
        #4;
        checks++; if (o0 !== O_STALL) begin errors++; $display("FAIL lu_regB got %b want %b", o0, O_STALL); end
        step();
        set_load_use(5'd0, 5'd0, 5'd0);
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL lu_r0 got %b want %b", o0, O_NONE); end
        step();
        set_load_use(5'd5, 5'd5, 5'd9);
        if0.dec_valid = 1'b0;
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL lu_dec_invalid got %b want %b", o0, O_NONE); end
        step();
        set_load_use(5'd5, 5'd5, 5'd9);
        if0.ex_opcode = OP_RTYPE;
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL lu_not_lw got %b want %b", o0, O_NONE); end
        step();
        set_load_use(5'd5, 5'd5, 5'd9);
        if0.ex_valid = 1'b0;
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL lu_ex_invalid got %b want %b", o0, O_NONE); end
        step();
        idle_inputs();
    endtask

    task automatic test_branch_priority();
        set_load_use(5'd5, 5'd5, 5'd9);
        if0.ex_branch_taken = 1'b1;
        #4;
        checks++; if (o0 !== O_FLUSH) begin errors++; $display("FAIL br_over_lu got %b want %b", o0, O_FLUSH); end
        step();
        idle_inputs();
        set_dec_md(ALU_MUL);
        if0.ex_branch_taken = 1'b1;
        #4;
        checks++; if (o0 !== O_FLUSH) begin errors++; $display("FAIL br_over_md got %b want %b", o0, O_FLUSH); end
        step();
        idle_inputs();
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL br_no_busy got %b want %b", o0, O_NONE); end
        step();
        set_load_use(5'd4, 5'd4, 5'd1);
        if0.dec_opcode = OP_RTYPE;
        if0.dec_alu_op = ALU_DIV;
        #4;
        checks++; if (o0 !== O_STALL) begin errors++; $display("FAIL lu_over_md got %b want %b", o0, O_STALL); end
        step();
        idle_inputs();
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL lu_no_busy got %b want %b", o0, O_NONE); end
        step();
    endtask

    task automatic test_multdiv();
        set_dec_md(ALU_MUL);
        #4;
        checks++; if (o0 !== O_START) begin errors++; $display("FAIL md_start got %b want %b", o0, O_START); end
        step();
        idle_inputs();
        for (int k = 1; k <= 16; k++) begin
            if0.ex_branch_taken = (k == 5);
            #4;
            checks++; if (o0 !== O_BUSY) begin errors++; $display("FAIL md_busy_%0d got %b want %b", k, o0, O_BUSY); end
            step();
        end
        if0.ex_branch_taken = 1'b0;
        if0.md_ready = 1'b1;
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL md_release got %b want %b", o0, O_NONE); end
        step();
        if0.md_ready = 1'b0;
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL md_idle_after got %b want %b", o0, O_NONE); end
        step();
    endtask

    task automatic test_back_to_back();
        set_dec_md(ALU_DIV);
        #4;
        checks++; if (o0 !== O_START) begin errors++; $display("FAIL b2b_first_start got %b want %b", o0, O_START); end
        step();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            #4;
            checks++; if (o0 !== O_BUSY) begin errors++; $display("FAIL b2b_busy_%0d got %b want %b", k, o0, O_BUSY); end
            step();
        end
        if0.md_ready = 1'b1;
        set_dec_md(ALU_MUL);
        #4;
        checks++; if (o0 !== O_START) begin errors++; $display("FAIL b2b_restart got %b want %b", o0, O_START); end
        step();
        idle_inputs();
        #4;
        checks++; if (o0 !== O_BUSY) begin errors++; $display("FAIL b2b_second_busy got %b want %b", o0, O_BUSY); end
        step();
        if0.md_ready = 1'b1;
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL b2b_release got %b want %b", o0, O_NONE); end
        step();
        idle_inputs();
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL b2b_idle got %b want %b", o0, O_NONE); end
        step();
    endtask

    task automatic test_timeout();
        set_dec_md(ALU_MUL);
        #4;
        checks++; if (o1 !== O_START) begin errors++; $display("FAIL to_start got %b want %b", o1, O_START); end
        step();
        idle_inputs();
        for (int k = 1; k <= 8; k++) begin
            #4;
            checks++;
            if (o1 !== ((k == 8) ? O_TOUT : O_BUSY)) begin
                errors++; $display("FAIL to_cycle_%0d got %b want %b", k, o1, (k == 8) ? O_TOUT : O_BUSY);
            end
            step();
        end
        #4;
        checks++; if (o1 !== O_NONE) begin errors++; $display("FAIL to_back_idle got %b want %b", o1, O_NONE); end
        checks++; if (o0 !== O_BUSY) begin errors++; $display("FAIL to_long_still_busy got %b want %b", o0, O_BUSY); end
        step();
        if0.md_ready = 1'b1;
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL to_long_release got %b want %b", o0, O_NONE); end
        step();
        idle_inputs();
        // md_ready on the watchdog cycle: ready wins, no timeout pulse
        set_dec_md(ALU_DIV);
        step();
        idle_inputs();
        for (int k = 1; k <= 7; k++) step();
        if0.md_ready = 1'b1;
        #4;
        checks++; if (o1 !== O_NONE) begin errors++; $display("FAIL to_tie_ready_wins got %b want %b", o1, O_NONE); end
        step();
        idle_inputs();
        #4;
        checks++; if (o1 !== O_NONE) begin errors++; $display("FAIL to_tie_idle got %b want %b", o1, O_NONE); end
        step();
    endtask

    task automatic test_reset_mid_busy();
        set_dec_md(ALU_MUL);
        step();
        idle_inputs();
        step();
        step();
        reset = 1'b1;  // third MD_BUSY cycle
        step();
        reset = 1'b0;
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL rst_mid_idle got %b want %b", o0, O_NONE); end
        checks++; if (o1 !== O_NONE) begin errors++; $display("FAIL rst_mid_idle_to got %b want %b", o1, O_NONE); end
        step();
        if0.md_ready = 1'b1;
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL rst_ready_ignored got %b want %b", o0, O_NONE); end
        step();
        idle_inputs();
        #4;
        checks++; if (o0 !== O_NONE) begin errors++; $display("FAIL rst_after_ready got %b want %b", o0, O_NONE); end
        step();
        // reset landing on the watchdog cycle suppresses the timeout pulse
        set_dec_md(ALU_MUL);
        step();
        idle_inputs();
        for (int k = 1; k <= 7; k++) step();
        reset = 1'b1;
        #4;
        checks++; if (if1.md_timeout !== 1'b0) begin errors++; $display("FAIL rst_no_timeout got %b want 0", if1.md_timeout); end
        step();
        reset = 1'b0;
        #4;
        checks++; if (o1 !== O_NONE) begin errors++; $display("FAIL rst_to_idle got %b want %b", o1, O_NONE); end
        step();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        perf_clear = 1'b1;
        step();
        perf_clear = 1'b0;
        #4;
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL perf_zero got %0d want 0", stall_cycles); end
        set_load_use(5'd6, 5'd6, 5'd0);
        step();
        idle_inputs();
        set_dec_md(ALU_MUL);
        step();
        idle_inputs();
        for (int k = 1; k <= 10; k++) step();
        if0.md_ready = 1'b1;
        step();
        idle_inputs();
        #4;
        checks++; if (stall_cycles !== 32'd11) begin errors++; $display("FAIL perf_eleven got %0d want 11", stall_cycles); end
        set_load_use(5'd6, 5'd6, 5'd0);
        perf_clear = 1'b1;
        step();
        perf_clear = 1'b0;
        #4;
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL perf_clear_wins got %0d want 0", stall_cycles); end
        step();
        idle_inputs();
        #4;
        checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL perf_after_clear got %0d want 1", stall_cycles); end
        step();
    endtask
`endif

    initial begin
`ifdef HAZARD_PERF_CNT_EN
        perf_clear = 1'b0;
`endif
        reset = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_load_use();
        test_branch_priority();
        test_multdiv();
        test_back_to_back();
        test_timeout();
        test_reset_mid_busy();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
